// File: rtl/mpadd_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared serial multi-precision adder.
// Optional WAIT watchdog enabled by defining MPADD_ARB_TIMEOUT_EN.
module mpadd_arbiter #(
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0_in,
  input  logic [WIDTH-1:0] b0_in,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1_in,
  input  logic [WIDTH-1:0] b1_in,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH:0]   result_out,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_write,
  output logic             add_start,
  input  logic [WIDTH:0]   add_s,
  input  logic             add_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mpadd_arbiter: TIMEOUT must be nonzero");
  end

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             arb_any;
  logic             arb_sel;

`ifdef MPADD_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // On a tie the requester that was not served last wins; a lone request always wins.
  assign arb_any = req0 | req1;
  assign arb_sel = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    result_d = result_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
`ifdef MPADD_ARB_TIMEOUT_EN
    err_d    = err_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      // DONE re-arbitrates on its exit edge so back-to-back grants skip an idle cycle.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (arb_any) begin
          state_d = S_LOAD;
          sel_d   = arb_sel;
          last_d  = arb_sel;
          add_a_d = arb_sel ? a1_in : a0_in;
          add_b_d = arb_sel ? b1_in : b0_in;
        end
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
`ifdef MPADD_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (add_ready) begin
          result_d = add_s;
          state_d  = S_DONE;
`ifdef MPADD_ARB_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
`ifdef MPADD_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      result_q <= result_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
`ifdef MPADD_ARB_TIMEOUT_EN
      err_q    <= err_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign gnt0       = busy & ~sel_q;
  assign gnt1       = busy & sel_q;
  assign done0      = (state_q == S_DONE) & ~sel_q;
  assign done1      = (state_q == S_DONE) & sel_q;
  assign add_write  = (state_q == S_LOAD);
  assign add_start  = (state_q == S_START);
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign result_out = result_q;
`ifdef MPADD_ARB_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mpadd_arbiter.sv
// Directed bench for mpadd_arbiter with an 8-limb serial adder model.
module tb_mpadd_arbiter;
  localparam int unsigned WIDTH   = 256;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LIMBS   = 8;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] a0_in = '0, b0_in = '0, a1_in = '0, b1_in = '0;
  logic             gnt0, gnt1, done0, done1, err, busy;
  logic [WIDTH:0]   result_out;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_write, add_start;
  logic [WIDTH:0]   add_s;
  logic             add_ready;

  logic             no_ready = 1'b0;
  logic [WIDTH:0]   m_sum = '0;
  logic             m_run = 1'b0;
  int unsigned      m_cnt = 0;
  logic             d0_seen = 1'b0, d1_seen = 1'b0;
  int unsigned      total = 0, bad = 0;
  logic [WIDTH:0]   exp_v;

  always #5 CLK = ~CLK;

  mpadd_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0(req0), .a0_in(a0_in), .b0_in(b0_in),
    .req1(req1), .a1_in(a1_in), .b1_in(b1_in),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result_out(result_out), .err(err), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_write(add_write), .add_start(add_start),
    .add_s(add_s), .add_ready(add_ready)
  );

  // Adder model: not reset by RST_N; write clears its limb counter, ready after LIMBS cycles.
  always @(posedge CLK) begin
    if (add_write) begin
      m_sum <= {1'b0, add_a} + {1'b0, add_b};
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (add_start) begin
      m_run <= 1'b1;
      m_cnt <= 1;
    end else if (m_run) begin
      if (m_cnt == LIMBS) m_run <= 1'b0;
      else m_cnt <= m_cnt + 1;
    end
  end
  assign add_ready = m_run && (m_cnt == LIMBS) && !no_ready;
  assign add_s     = add_ready ? m_sum : {(WIDTH+1){1'b1}};

  task automatic chk(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (done0) d0_seen = 1'b1;
    if (done1) d1_seen = 1'b1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; req0 = 1'b0; req1 = 1'b0; no_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    d0_seen = 1'b0; d1_seen = 1'b0;
  endtask

  initial begin
    int unsigned loads;
    logic [5:0]  order;

    // Reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_strobes", {add_write, add_start}, 0);
    chk("rst_result", result_out, 0);
    chk("rst_err", err, 0);
    chk("rst_add_a", add_a, 0);
    @(negedge CLK); RST_N = 1'b1;

    // Single request with full carry-out
    a0_in = '1; b0_in = 1; req0 = 1'b1;
    step();
    chk("t1_write_c1", add_write, 1);
    chk("t1_gnt0_c1", gnt0, 1);
    chk("t1_add_a", add_a, {1'b0, {WIDTH{1'b1}}});
    chk("t1_add_b", add_b, 1);
    step();
    chk("t1_start_c2", {add_write, add_start}, 2'b01);
    steps(8);
    chk("t1_no_early_done", d0_seen, 0);
    step();
    chk("t1_done0_c11", done0, 1);
    exp_v = '0; exp_v[WIDTH] = 1'b1;
    chk("t1_result", result_out, exp_v);
    chk("t1_err", err, 0);
    req0 = 1'b0;
    step();
    chk("t1_idle", busy, 0);
    chk("t1_no_done1", d1_seen, 0);

    // Simultaneous first request: 0 first, 1 back-to-back
    do_reset();
    a0_in = 5; b0_in = 7; a1_in = 100; b1_in = 1;
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("t2_first_gnt", {gnt1, gnt0}, 2'b01);
    chk("t2_add_a0", add_a, 5);
    steps(10);
    chk("t2_done0", {done1, done0}, 2'b01);
    chk("t2_sum0", result_out, 12);
    req0 = 1'b0;
    step();
    chk("t2_second_gnt_c12", {gnt1, gnt0, add_write}, 3'b101);
    chk("t2_add_a1", add_a, 100);
    steps(10);
    chk("t2_done1", {done1, done0}, 2'b10);
    chk("t2_sum1", result_out, 101);
    req1 = 1'b0;
    step();
    chk("t2_idle", busy, 0);

    // Round-robin fairness over 6 transactions
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    loads = 0; order = '0;
    for (int unsigned c = 1; c <= 66; c++) begin
      step();
      if (add_write && loads < 6) begin
        order[loads] = gnt1;
        loads++;
      end
      if (c == 66) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    chk("t3_loads", loads, 6);
    chk("t3_order", order, 6'b101010);
    chk("t3_last_sum", result_out, 101);

    // Reset during WAIT cycle 4, then a fresh request from 1
    @(negedge CLK);
    a0_in = 3; b0_in = 4; req0 = 1'b1;
    steps(6);
    chk("t4_busy_before", busy, 1);
    RST_N = 1'b0; req0 = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_gnt", {gnt1, gnt0, done1, done0}, 0);
    chk("t4_rst_add_a", add_a, 0);
    chk("t4_rst_result", result_out, 0);
    @(negedge CLK); RST_N = 1'b1;
    d0_seen = 1'b0; d1_seen = 1'b0;
    steps(8);
    chk("t4_stale_ready_ignored", {busy, d1_seen, d0_seen}, 0);
    @(negedge CLK);
    a1_in = 'h1234; b1_in = 'hFFFF_FFFF; req1 = 1'b1;
    step();
    chk("t4_gnt1", {gnt1, add_write}, 2'b11);
    steps(10);
    chk("t4_done1", done1, 1);
    chk("t4_sum", result_out, 'h1_0000_1233);
    req1 = 1'b0;
    step();
    chk("t4_no_done0", d0_seen, 0);

    // Adder that never signals ready
    @(negedge CLK);
    no_ready = 1'b1; d0_seen = 1'b0;
    a0_in = 9; b0_in = 9; req0 = 1'b1;
`ifdef MPADD_ARB_TIMEOUT_EN
    steps(18);
    chk("t5_no_early_done", d0_seen, 0);
    step();
    chk("t5_done0_c19", done0, 1);
    chk("t5_err", err, 1);
    chk("t5_result_held", result_out, 'h1_0000_1233);
    req0 = 1'b0;
    step();
    chk("t5_idle", busy, 0);
`else
    steps(40);
    chk("t5_busy_held", busy, 1);
    chk("t5_err_zero", err, 0);
    chk("t5_no_done", d0_seen, 0);
    chk("t5_result_held", result_out, 'h1_0000_1233);
`endif
    do_reset();
    chk("t5_reset_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mpadd_arbiter.md
Name: mpadd_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared serial 256-bit multi-precision adder.
- The adder takes 32-bit limbs, processes one limb per cycle, and uses a write/start/ready interface.
- This block grants one requester and loads that requester's operands into the adder with a one-cycle write.
- It then pulses start, waits for ready, captures the (WIDTH+1)-bit sum into a holding register and returns it with a one-cycle done pulse to the served requester.

Parameters:
- WIDTH, 256: operand width in bits; must equal the adder operand width.
- TIMEOUT, 16: watchdog limit in WAIT cycles; used only with MPADD_ARB_TIMEOUT_EN.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- req0  input  1  requester 0 request; held high until done0.
- a0_in  input  WIDTH  requester 0 operand A; stable while req0 is high.
- b0_in  input  WIDTH  requester 0 operand B; stable while req0 is high.
- req1  input  1  requester 1 request.
- a1_in  input  WIDTH  requester 1 operand A.
- b1_in  input  WIDTH  requester 1 operand B.
- gnt0  output  1  requester 0 owns the adder (LOAD through DONE).
- gnt1  output  1  requester 1 owns the adder.
- done0  output  1  one-cycle pulse: result_out is valid for requester 0.
- done1  output  1  one-cycle pulse: result_out is valid for requester 1.
- result_out  output  WIDTH+1  captured sum, including the carry-out MSB.
- err  output  1  timeout flag, qualified by done0/done1.
- busy  output  1  state is not IDLE.
- add_a  output  WIDTH  operand A to the adder.
- add_b  output  WIDTH  operand B to the adder.
- add_write  output  1  adder operand load strobe.
- add_start  output  1  adder start strobe.
- add_s  input  WIDTH+1  adder sum.
- add_ready  input  1  adder one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, RST_N low):
  - state=IDLE, last=1 (requester 0 wins the first tie).
  - result_out=0, err=0.
  - All strobes, grants, done and busy low.
  - add_a and add_b are 0 (reset value of each output).
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE:
  - Sample req0/req1 on each rising edge.
  - Only one request high: grant it.
  - Both high: grant the requester that is not `last`, then set last to the granted index.
  - A grant moves to LOAD; otherwise stay in IDLE.
- LOAD:
  - add_write=1; add_a and add_b are muxed from the granted requester.
  - Next state: START.
  - LOAD is mandatory before every START. It clears the adder's internal limb counter, which is not reset by RST_N.
- START:
  - add_start=1 for exactly one cycle; add_a and add_b remain driven.
  - Next state: WAIT.
- WAIT:
  - add_start=0.
  - When add_ready=1: result_out<=add_s, err<=0, next state DONE.
  - add_ready is sampled only in WAIT and ignored in all other states.
- DONE:
  - done of the granted requester = 1; its grant remains high.
  - Next state: IDLE.
- Output decode:
  - add_write, add_start, gnt0/1, done0/1 and busy are decoded from the registered state and grant index.
  - No combinational path from req to any output.
- Latency:
  - With an 8-limb adder: 1 LOAD + 1 START + 8 WAIT + 1 DONE.
  - done is high in the 11th cycle after the IDLE edge that accepted the request.
  - The next grant is evaluated at the edge that leaves DONE; the earliest new LOAD is 12 cycles after the previous acceptance.
- Requester protocol:
  - Drop req in the cycle done is seen.
  - If req is still high at the IDLE edge, it is treated as a new request and still subject to round-robin.
- Change on req or operands while granted: undefined, and not checked.
- result_out holds its value until the next capture.
- Reset mid-operation: abort immediately and return all outputs to reset values. No done is issued for the aborted request.

Optional Feature:
- Macro: MPADD_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT without add_ready: err<=1, result_out is left unchanged, next state DONE.
  - done pulses normally, and the grant is consumed (last updated).
- Undefined:
  - No counter; WAIT waits indefinitely.
  - err is tied to 0.

Test Plan:
- Single request: req0=1, a0=2^256-1, b0=1 -> add_write high in cycle 1, add_start in cycle 2; done0 pulses in cycle 11; result_out=2^256; done1 never asserts.
- Simultaneous first request: req0=req1=1 from reset -> gnt0 first; then gnt1 with the next LOAD 12 cycles after acceptance; each done carries its own sum (a0=5,b0=7 gives 12; a1=100,b1=1 gives 101).
- Round-robin fairness: both requests held continuously for 6 transactions -> grant order 0,1,0,1,0,1, with no back-to-back grant to the same requester.
- Reset in WAIT: assert RST_N low during WAIT cycle 4 -> all outputs 0 immediately, no done; after release, a new req1 completes correctly (LOAD re-zeros the adder).
- Timeout (macro defined, TIMEOUT=16): adder model never pulses ready -> done0 in cycle 2+16+1, err=1, result_out unchanged. With the macro undefined: busy stays high indefinitely and err stays 0.
